// File: rtl/arb_pkg.sv
// Shared constants and helpers for the priority / round-robin arbiter.
package arb_pkg;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   // Descending index wrap, modulo n rather than a power of two.
   function automatic int unsigned wrap_dec(input int unsigned i, input int unsigned n);
      return (i == 0) ? n - 1 : i - 1;
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-to-W encoder: reports the highest set index and whether any bit is set.
module prio_enc_n #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-input arbiter with registered grant, valid/ready handshake and
// runtime fixed-priority / round-robin selection.
import arb_pkg::*;

module prio_rr_arbiter #(
   parameter  int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         mode_i,
   input  logic         gnt_ready_i,
   output logic         gnt_valid_o,
   output logic [W-1:0] gnt_idx_o,
   output logic [N-1:0] gnt_onehot_o
);

   logic [W-1:0] ptr_q, ptr_d;
   logic         gnt_valid_q;
   logic [W-1:0] gnt_idx_q;
   logic [N-1:0] gnt_onehot_q;

   logic         accept, slot;
   logic [N-1:0] mask_le, req_masked;
   logic [W-1:0] m_idx, u_idx, win_idx;
   logic         m_found, u_found, win_found;
   logic [N-1:0] onehot_d;

   always_comb begin
      accept = gnt_valid_q && gnt_ready_i;
      slot   = !gnt_valid_q || gnt_ready_i;
      ptr_d  = ptr_q;
      if (accept && (mode_i == ARB_MODE_RR)) begin
         ptr_d = W'(wrap_dec(32'(gnt_idx_q), N));
      end
   end

   // Re-arbitration in the accept cycle searches from the already-advanced pointer.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         mask_le[i] = (i <= 32'(ptr_d));
      end
      req_masked = req_i & mask_le;
   end

   prio_enc_n #(
      .N (N),
      .W (W)
   ) u_enc_masked (
      .req_i   (req_masked),
      .idx_o   (m_idx),
      .found_o (m_found)
   );

   prio_enc_n #(
      .N (N),
      .W (W)
   ) u_enc_full (
      .req_i   (req_i),
      .idx_o   (u_idx),
      .found_o (u_found)
   );

   always_comb begin
      win_found = u_found;
      win_idx   = u_idx;
      if ((mode_i == ARB_MODE_RR) && m_found) begin
         win_idx = m_idx;
      end
      for (int unsigned i = 0; i < N; i++) begin
         onehot_d[i] = win_found && (32'(win_idx) == i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= W'(N - 1);
         gnt_valid_q  <= 1'b0;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
      end else if (slot) begin
         ptr_q        <= ptr_d;
         gnt_valid_q  <= win_found;
         gnt_idx_q    <= win_idx;
         gnt_onehot_q <= onehot_d;
      end
   end

   assign gnt_valid_o  = gnt_valid_q;
   assign gnt_idx_o    = gnt_idx_q;
   assign gnt_onehot_o = gnt_onehot_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Scoreboard bench for prio_rr_arbiter at N=8 and N=5 against a rotation-search reference model.
module tb_prio_rr_arbiter;

   typedef struct {
      bit valid;
      int idx;
      int ptr;
   } ms_t;

   typedef struct {
      bit valid;
      int idx;
      int oh;
      int ptr;
   } exp_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   logic       rst8, mode8, rdy8, vld8;
   logic [7:0] req8, oh8;
   logic [2:0] idx8;

   logic       rst5, mode5, rdy5, vld5;
   logic [4:0] req5, oh5;
   logic [2:0] idx5;

   exp_t q8[$];
   exp_t q5[$];
   ms_t  m8, m5;

   prio_rr_arbiter #(.N(8)) dut8 (
      .clk_i        (clk),
      .rst_i        (rst8),
      .req_i        (req8),
      .mode_i       (mode8),
      .gnt_ready_i  (rdy8),
      .gnt_valid_o  (vld8),
      .gnt_idx_o    (idx8),
      .gnt_onehot_o (oh8)
   );

   prio_rr_arbiter #(.N(5)) dut5 (
      .clk_i        (clk),
      .rst_i        (rst5),
      .req_i        (req5),
      .mode_i       (mode5),
      .gnt_ready_i  (rdy5),
      .gnt_valid_o  (vld5),
      .gnt_idx_o    (idx5),
      .gnt_onehot_o (oh5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: next grant state computed by walking candidates in search order.
   function automatic ms_t step(ms_t s, int n, bit r, logic [7:0] rq, bit md, bit rd);
      ms_t t = s;
      if (r) begin
         t.valid = 1'b0;
         t.idx   = 0;
         t.ptr   = n - 1;
         return t;
      end
      if (s.valid && !rd) return t;
      if (s.valid && md) t.ptr = (s.idx + n - 1) % n;
      t.valid = 1'b0;
      t.idx   = 0;
      for (int k = 0; k < n; k++) begin
         int c;
         c = md ? (t.ptr - k + n) % n : n - 1 - k;
         if (rq[c]) begin
            t.valid = 1'b1;
            t.idx   = c;
            break;
         end
      end
      return t;
   endfunction

   function automatic exp_t to_exp(ms_t s);
      exp_t e;
      e.valid = s.valid;
      e.idx   = s.idx;
      e.oh    = s.valid ? (1 << s.idx) : 0;
      e.ptr   = s.ptr;
      return e;
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic drive8(bit r, logic [7:0] rq, bit md, bit rd);
      @(negedge clk);
      rst8 = r; req8 = rq; mode8 = md; rdy8 = rd;
      m8 = step(m8, 8, r, rq, md, rd);
      q8.push_back(to_exp(m8));
   endtask

   task automatic drive5(bit r, logic [4:0] rq, bit md, bit rd);
      @(negedge clk);
      rst5 = r; req5 = rq; mode5 = md; rdy5 = rd;
      m5 = step(m5, 5, r, {3'b000, rq}, md, rd);
      q5.push_back(to_exp(m5));
   endtask

   initial begin : mon8
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("n8_valid", int'(vld8), int'(e.valid));
            chk("n8_idx", int'(idx8), e.idx);
            chk("n8_onehot", int'(oh8), e.oh);
            chk("n8_ptr", int'(dut8.ptr_q), e.ptr);
         end
      end
   end

   initial begin : mon5
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q5.size() > 0) begin
            e = q5.pop_front();
            chk("n5_valid", int'(vld5), int'(e.valid));
            chk("n5_idx", int'(idx5), e.idx);
            chk("n5_onehot", int'(oh5), e.oh);
            chk("n5_ptr", int'(dut5.ptr_q), e.ptr);
            chk("n5_ptr_range", int'(dut5.ptr_q < 3'd5), 1);
         end
      end
   end

   initial begin
      m8 = '{valid: 1'b0, idx: 0, ptr: 7};
      m5 = '{valid: 1'b0, idx: 0, ptr: 4};
      rst8 = 1'b1; req8 = '0; mode8 = 1'b0; rdy8 = 1'b1;
      rst5 = 1'b1; req5 = '0; mode5 = 1'b0; rdy5 = 1'b1;
      fork
         begin : seq8
            repeat (2) drive8(1'b1, 8'hFF, 1'b0, 1'b1);
            drive8(1'b0, 8'hFF, 1'b0, 1'b1);
            repeat (4) drive8(1'b0, 8'b1010_0100, 1'b0, 1'b1);
            repeat (10) drive8(1'b0, 8'hFF, 1'b1, 1'b1);
            repeat (4) drive8(1'b0, 8'b0010_0010, 1'b1, 1'b1);
            // Steer pointer so idx 6 is presented, then hold it under backpressure.
            drive8(1'b1, 8'hFF, 1'b1, 1'b1);
            drive8(1'b0, 8'h40, 1'b1, 1'b1);
            repeat (3) drive8(1'b0, 8'h01, 1'b1, 1'b0);
            repeat (2) drive8(1'b0, 8'h01, 1'b1, 1'b1);
            // Pending grant at low pointer, then reset mid-hold.
            repeat (5) drive8(1'b0, 8'hFF, 1'b1, 1'b1);
            drive8(1'b0, 8'hFF, 1'b1, 1'b0);
            drive8(1'b1, 8'hFF, 1'b1, 1'b0);
            repeat (2) drive8(1'b0, 8'hFF, 1'b1, 1'b1);
            drive8(1'b0, 8'h00, 1'b0, 1'b1);
            for (int i = 0; i < 400; i++) begin
               logic [7:0] rq;
               rq = 8'($urandom) & 8'($urandom);
               drive8($urandom_range(0, 49) == 0, rq, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 3) != 0));
            end
         end
         begin : seq5
            repeat (2) drive5(1'b1, 5'h1F, 1'b1, 1'b1);
            repeat (3) drive5(1'b0, 5'b00000, 1'b1, 1'b1);
            repeat (8) drive5(1'b0, 5'b10001, 1'b1, 1'b1);
            repeat (3) drive5(1'b0, 5'b00000, 1'b0, 1'b1);
            for (int i = 0; i < 300; i++) begin
               logic [4:0] rq;
               rq = 5'($urandom) & 5'($urandom);
               drive5($urandom_range(0, 49) == 0, rq, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) != 0));
            end
         end
      join
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q8.size() != 0 || q5.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q8.size(), q5.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
